// File: rtl/issue_scoreboard_pkg.sv
// Shared decoder/issue/execute definitions: instruction-type codes and the decoded payload.
package issue_scoreboard_pkg;
  localparam int PKG_WIDTH            = 32;
  localparam int PKG_REG_WIDTH        = 5;
  localparam int PKG_INSTR_TYPE_WIDTH = 8;

  localparam logic [PKG_INSTR_TYPE_WIDTH-1:0] ILLEGAL_TYPE = 8'h7F;

  typedef enum logic [PKG_INSTR_TYPE_WIDTH-1:0] {
    TYPE_NOP     = 8'h00,
    TYPE_ALU     = 8'h01,
    TYPE_ALUI    = 8'h02,
    TYPE_LOAD    = 8'h03,
    TYPE_STORE   = 8'h04,
    TYPE_BRANCH  = 8'h05,
    TYPE_JUMP    = 8'h06,
    TYPE_ILLEGAL = 8'h7F
  } instr_type_e;

  typedef struct packed {
    instr_type_e                itype;
    logic [PKG_WIDTH-1:0]       imm;
    logic [PKG_REG_WIDTH-1:0]   rs1;
    logic [PKG_REG_WIDTH-1:0]   rs2;
    logic [PKG_REG_WIDTH-1:0]   rd;
    logic                       rs1e;
    logic                       rs2e;
    logic                       rde;
  } dec_instr_t;
endpackage

// File: rtl/issue_scoreboard_reg_scoreboard.sv
// Busy-bit register scoreboard with set-over-clear priority and x0 masking.
// SCOREBOARD_WB_BYPASS_EN: read ports see the same-cycle writeback clear.
module reg_scoreboard #(
  parameter int REG_WIDTH = 5,
  parameter int NUM_REGS  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_set,
  input  logic [REG_WIDTH-1:0] i_set_rd,
  input  logic                 i_clr,
  input  logic [REG_WIDTH-1:0] i_clr_rd,
  input  logic [REG_WIDTH-1:0] i_rd_a,
  input  logic [REG_WIDTH-1:0] i_rd_b,
  input  logic [REG_WIDTH-1:0] i_rd_c,
  output logic                 o_busy_a,
  output logic                 o_busy_b,
  output logic                 o_busy_c,
  output logic [NUM_REGS-1:0]  o_busy
);
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_rd_vec;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set) w_set_mask[i_set_rd] = 1'b1;
    if (i_clr) w_clr_mask[i_clr_rd] = 1'b1;
    // x0 is hardwired: it can never become busy
    w_set_mask[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_busy <= '0;
    else        r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
  end

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign w_rd_vec = r_busy & ~w_clr_mask;
`else
  assign w_rd_vec = r_busy;
`endif

  assign o_busy_a = w_rd_vec[i_rd_a];
  assign o_busy_b = w_rd_vec[i_rd_b];
  assign o_busy_c = w_rd_vec[i_rd_c];
  assign o_busy   = r_busy;
endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue stage: holds a decoded instruction until its registers are hazard-free.
// SCOREBOARD_WB_BYPASS_EN lets a dependent issue in the same cycle as its writeback.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int REG_WIDTH        = 5,
  parameter int NUM_REGS         = 32,
  parameter int INSTR_TYPE_WIDTH = 8,
  parameter int STALL_CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [INSTR_TYPE_WIDTH-1:0] in_type,
  input  logic [WIDTH-1:0]            in_imm,
  input  logic [REG_WIDTH-1:0]        in_rs1,
  input  logic [REG_WIDTH-1:0]        in_rs2,
  input  logic [REG_WIDTH-1:0]        in_rd,
  input  logic                        in_rs1e,
  input  logic                        in_rs2e,
  input  logic                        in_rde,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INSTR_TYPE_WIDTH-1:0] out_type,
  output logic [WIDTH-1:0]            out_imm,
  output logic [REG_WIDTH-1:0]        out_rs1,
  output logic [REG_WIDTH-1:0]        out_rs2,
  output logic [REG_WIDTH-1:0]        out_rd,
  output logic                        out_rs1e,
  output logic                        out_rs2e,
  output logic                        out_rde,
  input  logic                        wb_valid,
  input  logic [REG_WIDTH-1:0]        wb_rd,
  input  logic                        flush,
  output logic                        illegal,
  output logic [NUM_REGS-1:0]         busy,
  output logic [STALL_CNT_WIDTH-1:0]  stall_cnt
);
  logic                        r_out_valid;
  logic [INSTR_TYPE_WIDTH-1:0] r_out_type;
  logic [WIDTH-1:0]            r_out_imm;
  logic [REG_WIDTH-1:0]        r_out_rs1, r_out_rs2, r_out_rd;
  logic                        r_out_rs1e, r_out_rs2e, r_out_rde;
  logic                        r_illegal;
  logic [STALL_CNT_WIDTH-1:0]  r_stall_cnt;

  logic w_busy_rs1, w_busy_rs2, w_busy_rd;
  logic w_is_illegal, w_hazard, w_slot_free, w_accept, w_issue, w_stall;

  reg_scoreboard #(.REG_WIDTH(REG_WIDTH), .NUM_REGS(NUM_REGS)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .i_set    (w_issue & in_rde),
    .i_set_rd (in_rd),
    .i_clr    (wb_valid),
    .i_clr_rd (wb_rd),
    .i_rd_a   (in_rs1),
    .i_rd_b   (in_rs2),
    .i_rd_c   (in_rd),
    .o_busy_a (w_busy_rs1),
    .o_busy_b (w_busy_rs2),
    .o_busy_c (w_busy_rd),
    .o_busy   (busy)
  );

  assign w_is_illegal = (in_type == INSTR_TYPE_WIDTH'(ILLEGAL_TYPE));
  assign w_hazard     = (in_rs1e & w_busy_rs1) | (in_rs2e & w_busy_rs2) | (in_rde & w_busy_rd);
  assign w_slot_free  = !r_out_valid | out_ready;
  // Illegal instructions are dropped, so their operands cannot cause a hazard
  assign in_ready     = !flush & w_slot_free & (w_is_illegal | !w_hazard);
  assign w_accept     = in_valid & in_ready;
  assign w_issue      = w_accept & !w_is_illegal;
  assign w_stall      = in_valid & !in_ready & !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_type  <= '0;
      r_out_imm   <= '0;
      r_out_rs1   <= '0;
      r_out_rs2   <= '0;
      r_out_rd    <= '0;
      r_out_rs1e  <= 1'b0;
      r_out_rs2e  <= 1'b0;
      r_out_rde   <= 1'b0;
      r_illegal   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_illegal <= w_accept & w_is_illegal;
      if (w_stall && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + STALL_CNT_WIDTH'(1);
      if (w_issue) begin
        r_out_valid <= 1'b1;
        r_out_type  <= in_type;
        r_out_imm   <= in_imm;
        r_out_rs1   <= in_rs1;
        r_out_rs2   <= in_rs2;
        r_out_rd    <= in_rd;
        r_out_rs1e  <= in_rs1e;
        r_out_rs2e  <= in_rs2e;
        r_out_rde   <= in_rde;
      end else if (flush || out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_type  = r_out_type;
  assign out_imm   = r_out_imm;
  assign out_rs1   = r_out_rs1;
  assign out_rs2   = r_out_rs2;
  assign out_rd    = r_out_rd;
  assign out_rs1e  = r_out_rs1e;
  assign out_rs2e  = r_out_rs2e;
  assign out_rde   = r_out_rde;
  assign illegal   = r_illegal;
  assign stall_cnt = r_stall_cnt;
endmodule
